// File: rtl/mult_div_unit.sv
// Iterative MIPS-style HI/LO unit: 32-cycle shift-add multiply and restoring divide,
// with MTHI/MTLO writes accepted only while the unit is idle.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] mt_data,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {IDLE, RUN} state_t;
    state_t state, state_next;

    logic [1:0]       op_q;
    logic [WIDTH-1:0] a_q, b_q, m_q;
    logic [WIDTH-1:0] acc_hi, acc_lo;
    logic [WIDTH-1:0] hi_q, lo_q;
    logic [CW-1:0]    cnt;
    logic             done_q, dbz_q;

    logic             accept, last_iter;
    logic             start_signed;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic             is_div, is_signed, b_zero;

    logic [WIDTH:0]     mul_sum, div_shift;
    logic               div_ge;
    logic [WIDTH-1:0]   div_sub;
    logic [WIDTH-1:0]   step_hi, step_lo;
    logic [2*WIDTH-1:0] prod_raw, prod_fin;
    logic [WIDTH-1:0]   fin_hi, fin_lo;

    assign accept    = (state == IDLE) && start;
    assign last_iter = (state == RUN) && (cnt == LAST);
    assign is_div    = op_q[1];
    assign is_signed = ~op_q[0];
    assign b_zero    = (b_q == '0);

    // Signed ops iterate on magnitudes; the raw operands are kept for sign fix-up.
    always_comb begin
        start_signed = ~op[0];
        a_mag = (start_signed && operand_a[WIDTH-1]) ? -operand_a : operand_a;
        b_mag = (start_signed && operand_b[WIDTH-1]) ? -operand_b : operand_b;
    end

    always_comb begin
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, m_q} : '0);
        div_shift = {acc_hi, acc_lo[WIDTH-1]};
        div_ge    = div_shift >= {1'b0, m_q};
        div_sub   = div_shift[WIDTH-1:0] - m_q;
        if (is_div) begin
            step_hi = div_ge ? div_sub : div_shift[WIDTH-1:0];
            step_lo = {acc_lo[WIDTH-2:0], div_ge};
        end else begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
        end
    end

    // Quotient sign follows both operands, remainder sign follows the dividend.
    always_comb begin
        prod_raw = {step_hi, step_lo};
        prod_fin = (is_signed && (a_q[WIDTH-1] ^ b_q[WIDTH-1])) ? -prod_raw : prod_raw;
        fin_hi   = prod_fin[2*WIDTH-1:WIDTH];
        fin_lo   = prod_fin[WIDTH-1:0];
        if (is_div) begin
            if (b_zero) begin
                fin_hi = a_q;
                fin_lo = '1;
            end else begin
                fin_lo = (is_signed && (a_q[WIDTH-1] ^ b_q[WIDTH-1])) ? -step_lo : step_lo;
                fin_hi = (is_signed && a_q[WIDTH-1]) ? -step_hi : step_hi;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start)     state_next = RUN;
            RUN:     if (last_iter) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        if (state == RUN) busy = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            m_q    <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            cnt    <= '0;
            done_q <= 1'b0;
            dbz_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            dbz_q  <= 1'b0;
            if (accept) begin
                op_q   <= op;
                a_q    <= operand_a;
                b_q    <= operand_b;
                m_q    <= op[1] ? b_mag : a_mag;
                acc_hi <= '0;
                acc_lo <= op[1] ? a_mag : b_mag;
                cnt    <= '0;
            end else if (state == IDLE) begin
                if (mthi) hi_q <= mt_data;
                if (mtlo) lo_q <= mt_data;
            end else begin
                acc_hi <= step_hi;
                acc_lo <= step_lo;
                cnt    <= cnt + CW'(1);
                if (last_iter) begin
                    hi_q   <= fin_hi;
                    lo_q   <= fin_lo;
                    done_q <= 1'b1;
                    dbz_q  <= is_div && b_zero;
                end
            end
        end
    end

    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed corner cases plus random
// operations compared against a plain-arithmetic HI/LO model.
module tb_mult_div_unit;
    logic        clk = 1'b0;
    logic        reset, start, mthi, mtlo;
    logic [1:0]  op;
    logic [31:0] operand_a, operand_b, mt_data;
    logic        busy, done, div_by_zero;
    logic [31:0] hi, lo;

    int checks = 0;
    int errors = 0;

    mult_div_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .operand_a(operand_a), .operand_b(operand_b),
        .mthi(mthi), .mtlo(mtlo), .mt_data(mt_data),
        .busy(busy), .done(done), .div_by_zero(div_by_zero),
        .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    // Reference HI/LO results computed with 64-bit arithmetic.
    function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] eh, output logic [31:0] el, output logic ed);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        logic [63:0] p, q, r;
        ed = 1'b0;
        eh = '0;
        el = '0;
        case (o)
            2'b00: begin p = sa * sb; eh = p[63:32]; el = p[31:0]; end
            2'b01: begin p = {32'b0, a} * {32'b0, b}; eh = p[63:32]; el = p[31:0]; end
            default: begin
                if (b == 0) begin
                    el = 32'hFFFFFFFF; eh = a; ed = 1'b1;
                end else if (o == 2'b10) begin
                    q = sa / sb; r = sa % sb;
                    el = q[31:0]; eh = r[31:0];
                end else begin
                    el = a / b; eh = a % b;
                end
            end
        endcase
    endfunction

    // Called at a falling edge; returns at the falling edge where done is seen (or after a bound).
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] rhi, output logic [31:0] rlo, output logic rdbz,
                          output int cyc, output int busy_low, output logic busy_end);
        op = o; operand_a = a; operand_b = b; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        busy_low = 0;
        while (cyc < 40) begin
            if (busy !== 1'b1) busy_low++;
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (done === 1'b1) break;
        end
        rhi = hi; rlo = lo; rdbz = div_by_zero; busy_end = busy;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b1; mthi = 1'b1; mtlo = 1'b1; mt_data = 32'hCAFEF00D;
        op = 2'b01; operand_a = 32'd9; operand_b = 32'd9;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b want 0", done); end
        checks++; if (div_by_zero !== 1'b0) begin errors++; $display("[TB] FAIL reset_dbz: got %b want 0", div_by_zero); end
        checks++; if (hi !== 32'h0) begin errors++; $display("[TB] FAIL reset_hi: got %h want 0", hi); end
        checks++; if (lo !== 32'h0) begin errors++; $display("[TB] FAIL reset_lo: got %h want 0", lo); end
        reset = 1'b0; start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
    endtask

    task automatic test_directed();
        logic [31:0] rh, rl; logic rd, be; int cyc, bl;
        run_op(2'b00, 32'd7, 32'hFFFFFFFD, rh, rl, rd, cyc, bl, be);
        checks++; if (cyc !== 32) begin errors++; $display("[TB] FAIL mult_latency: got %0d want 32", cyc); end
        checks++; if (bl !== 0) begin errors++; $display("[TB] FAIL mult_busy: busy low %0d times want 0", bl); end
        checks++; if (be !== 1'b0) begin errors++; $display("[TB] FAIL mult_busy_done: got %b want 0", be); end
        checks++; if (rh !== 32'hFFFFFFFF || rl !== 32'hFFFFFFEB) begin errors++; $display("[TB] FAIL mult_neg: got %h_%h want ffffffff_ffffffeb", rh, rl); end
        run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, rh, rl, rd, cyc, bl, be);
        checks++; if (rh !== 32'hFFFFFFFE || rl !== 32'h00000001 || rd !== 1'b0) begin errors++; $display("[TB] FAIL multu_max: got %h_%h dbz=%b want fffffffe_00000001 dbz=0", rh, rl, rd); end
        run_op(2'b10, 32'hFFFFFFF9, 32'd2, rh, rl, rd, cyc, bl, be);
        checks++; if (rh !== 32'hFFFFFFFF || rl !== 32'hFFFFFFFD) begin errors++; $display("[TB] FAIL div_neg: got hi=%h lo=%h want ffffffff fffffffd", rh, rl); end
        run_op(2'b11, 32'd100, 32'd0, rh, rl, rd, cyc, bl, be);
        checks++; if (cyc !== 32) begin errors++; $display("[TB] FAIL dbz_latency: got %0d want 32", cyc); end
        checks++; if (rh !== 32'h64 || rl !== 32'hFFFFFFFF || rd !== 1'b1) begin errors++; $display("[TB] FAIL divu_zero: got hi=%h lo=%h dbz=%b want 64 ffffffff 1", rh, rl, rd); end
        @(negedge clk);
        checks++; if (div_by_zero !== 1'b0 || done !== 1'b0) begin errors++; $display("[TB] FAIL dbz_pulse: got dbz=%b done=%b want 0 0", div_by_zero, done); end
        run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, rh, rl, rd, cyc, bl, be);
        checks++; if (rh !== 32'h0 || rl !== 32'h80000000 || rd !== 1'b0) begin errors++; $display("[TB] FAIL div_overflow: got hi=%h lo=%h dbz=%b want 0 80000000 0", rh, rl, rd); end
    endtask

    task automatic test_random();
        logic [31:0] rh, rl, eh, el, a, b; logic rd, ed, be; logic [1:0] o; int cyc, bl;
        for (int i = 0; i < 40; i++) begin
            o = 2'($urandom_range(0, 3));
            a = $urandom;
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 9));
                2:       b = 32'hFFFFFFFF;
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 5) == 0) a = 32'h80000000;
            model(o, a, b, eh, el, ed);
            run_op(o, a, b, rh, rl, rd, cyc, bl, be);
            checks++;
            if (rh !== eh || rl !== el || rd !== ed || cyc !== 32) begin
                errors++;
                $display("[TB] FAIL random_op%0d: op=%0d a=%h b=%h got hi=%h lo=%h dbz=%b cyc=%0d want hi=%h lo=%h dbz=%b cyc=32",
                         i, o, a, b, rh, rl, rd, cyc, eh, el, ed);
            end
        end
    endtask

    task automatic test_start_while_busy();
        logic [31:0] eh, el, hi_before; logic ed; int cyc, bl;
        model(2'b00, 32'hFFFF1234, 32'h00ABCDEF, eh, el, ed);
        op = 2'b00; operand_a = 32'hFFFF1234; operand_b = 32'h00ABCDEF; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        hi_before = hi;
        cyc = 0; bl = 0;
        while (cyc < 40) begin
            if (busy !== 1'b1) bl++;
            start = (cyc == 5);
            mthi  = (cyc == 10);
            if (cyc == 5) begin op = 2'b11; operand_a = 32'd55; operand_b = 32'd3; end
            mt_data = 32'h0BADF00D;
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (cyc == 11) begin
                checks++;
                if (hi !== hi_before) begin errors++; $display("[TB] FAIL mthi_busy: got %h want %h", hi, hi_before); end
            end
            if (done === 1'b1) break;
        end
        start = 1'b0; mthi = 1'b0;
        checks++; if (cyc !== 32 || bl !== 0) begin errors++; $display("[TB] FAIL busy_start_timing: got cyc=%0d busy_low=%0d want 32 0", cyc, bl); end
        checks++; if (hi !== eh || lo !== el) begin errors++; $display("[TB] FAIL busy_start_result: got %h_%h want %h_%h", hi, lo, eh, el); end
        @(negedge clk);
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("[TB] FAIL busy_start_ignored: got busy=%b done=%b want 0 0", busy, done); end
    endtask

    task automatic test_mt();
        int cyc;
        mthi = 1'b1; mt_data = 32'h12345678;
        @(posedge clk);
        @(negedge clk);
        mthi = 1'b0;
        checks++; if (hi !== 32'h12345678) begin errors++; $display("[TB] FAIL mthi_idle: got %h want 12345678", hi); end
        mthi = 1'b1; mtlo = 1'b1; mt_data = 32'hA5A5C3C3;
        @(posedge clk);
        @(negedge clk);
        mthi = 1'b0; mtlo = 1'b0;
        checks++; if (hi !== 32'hA5A5C3C3 || lo !== 32'hA5A5C3C3) begin errors++; $display("[TB] FAIL mthi_mtlo: got hi=%h lo=%h want a5a5c3c3", hi, lo); end
        op = 2'b01; operand_a = 32'd3; operand_b = 32'd4; start = 1'b1; mthi = 1'b1; mtlo = 1'b1; mt_data = 32'hDEADBEEF;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        checks++; if (hi !== 32'hA5A5C3C3 || lo !== 32'hA5A5C3C3 || busy !== 1'b1) begin errors++; $display("[TB] FAIL start_wins: got hi=%h lo=%h busy=%b want a5a5c3c3 a5a5c3c3 1", hi, lo, busy); end
        cyc = 0;
        while (cyc < 40 && done !== 1'b1) begin
            @(posedge clk); cyc++; @(negedge clk);
        end
        checks++; if (cyc !== 32 || hi !== 32'h0 || lo !== 32'd12) begin errors++; $display("[TB] FAIL start_wins_result: got cyc=%0d hi=%h lo=%h want 32 0 c", cyc, hi, lo); end
    endtask

    task automatic test_reset_abort();
        logic [31:0] rh, rl, eh, el; logic rd, ed, be; int cyc, bl, done_seen;
        mthi = 1'b1; mtlo = 1'b1; mt_data = 32'h77778888;
        @(posedge clk); @(negedge clk);
        mthi = 1'b0; mtlo = 1'b0;
        op = 2'b10; operand_a = 32'd123456; operand_b = 32'd789; start = 1'b1;
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL abort_busy_before: got %b want 1", busy); end
        reset = 1'b1;
        @(posedge clk); @(negedge clk);
        reset = 1'b0;
        checks++; if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin errors++; $display("[TB] FAIL abort_state: got busy=%b hi=%h lo=%h want 0 0 0", busy, hi, lo); end
        model(2'b01, 32'hDEAD0001, 32'h00000123, eh, el, ed);
        run_op(2'b01, 32'hDEAD0001, 32'h00000123, rh, rl, rd, cyc, bl, be);
        checks++; if (cyc !== 32 || rh !== eh || rl !== el) begin errors++; $display("[TB] FAIL start_after_reset: got cyc=%0d %h_%h want 32 %h_%h", cyc, rh, rl, eh, el); end
        @(negedge clk);
        op = 2'b10; operand_a = 32'd5000; operand_b = 32'd7; start = 1'b1;
        @(posedge clk); @(negedge clk);
        start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); @(negedge clk);
        reset = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (done !== 1'b0) done_seen++;
            @(negedge clk);
        end
        checks++; if (done_seen !== 0 || hi !== 32'h0 || lo !== 32'h0) begin errors++; $display("[TB] FAIL abort_no_done: got done_pulses=%0d hi=%h lo=%h want 0 0 0", done_seen, hi, lo); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rh, rl, eh, el; logic rd, ed, be; int cyc, bl;
        run_op(2'b11, 32'd1000, 32'd7, rh, rl, rd, cyc, bl, be);
        checks++; if (rh !== 32'd6 || rl !== 32'd142) begin errors++; $display("[TB] FAIL b2b_first: got hi=%0d lo=%0d want 6 142", rh, rl); end
        model(2'b00, 32'hFFFFFF00, 32'h7FFFFFFF, eh, el, ed);
        run_op(2'b00, 32'hFFFFFF00, 32'h7FFFFFFF, rh, rl, rd, cyc, bl, be);
        checks++; if (cyc !== 32 || rh !== eh || rl !== el) begin errors++; $display("[TB] FAIL b2b_second: got cyc=%0d %h_%h want 32 %h_%h", cyc, rh, rl, eh, el); end
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        op = '0; operand_a = '0; operand_b = '0; mt_data = '0;
        @(negedge clk);
        test_reset();
        test_directed();
        test_random();
        test_start_while_busy();
        test_mt();
        test_reset_abort();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
